frame_dispatch: RTL and testbench

//  Sits directly downstream of the frame FIFO fed by the frame parser/CRC checker.

---
 rtl/frame_dispatch.sv | 133 +++++++++++++
 tb/tb_frame_dispatch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : frame_dispatch
// Brief    : Pops one frame-FIFO entry at a time, validates it and serializes
//            its payload words onto the one-hot selected output channel.
// Revision : 1.0 - initial release
// ============================================================================
module frame_dispatch #(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 8,
  parameter int MAX_WORDS = 8,
  parameter int ENTRY_W   = MAX_WORDS*DATA_W + NUM_CH + 4
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic [ENTRY_W-1:0] fifo_rdata,
  output logic [DATA_W-1:0]  dout,
  output logic [NUM_CH-1:0]  dout_vld,
  input  logic               dout_ready,
  output logic               frame_done,
  output logic               fmt_err,
  output logic               busy
);

  localparam int CNT_W = 4;
  localparam int IDX_W = $clog2(MAX_WORDS);
  localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_WORDS);
  localparam logic [IDX_W-1:0] c_idx_one = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [MAX_WORDS-1:0][DATA_W-1:0] r_words;
  logic [IDX_W-1:0]                 r_widx;
  logic [DATA_W-1:0]                r_dout;
  logic [NUM_CH-1:0]                r_vld;
  logic                             r_frame_done;
  logic                             r_fmt_err;

  logic [MAX_WORDS-1:0][DATA_W-1:0] w_in_words;
  logic [NUM_CH-1:0]                w_in_ch;
  logic [CNT_W-1:0]                 w_in_cnt;
  logic [IDX_W-1:0]                 w_in_last;
  logic [IDX_W-1:0]                 w_widx_dec;
  logic                             w_in_ok;
  logic                             w_last;

  assign w_in_words = fifo_rdata[ENTRY_W-1 -: MAX_WORDS*DATA_W];
  assign w_in_ch    = fifo_rdata[CNT_W +: NUM_CH];
  assign w_in_cnt   = fifo_rdata[CNT_W-1:0];
  // All four count bits take part in the range check, so 9..15 are rejected.
  assign w_in_ok    = (w_in_cnt != '0) && (w_in_cnt <= c_max_cnt) && $onehot(w_in_ch);
  assign w_in_last  = w_in_cnt[IDX_W-1:0] - c_idx_one;
  assign w_widx_dec = r_widx - c_idx_one;
  assign w_last     = (r_widx == '0);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (!fifo_empty) w_next = FETCH;
      FETCH:   w_next = LOAD;
      LOAD:    w_next = w_in_ok ? SEND : IDLE;
      SEND:    if (dout_ready && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The first word is loaded straight from the FIFO read data so it is on
  // the output the cycle after LOAD; later words come from the latched entry.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_words      <= '0;
      r_widx       <= '0;
      r_dout       <= '0;
      r_vld        <= '0;
      r_frame_done <= 1'b0;
      r_fmt_err    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_fmt_err    <= 1'b0;
      case (r_state)
        LOAD: begin
          if (w_in_ok) begin
            r_words <= w_in_words;
            r_widx  <= w_in_last;
            r_dout  <= w_in_words[w_in_last];
            r_vld   <= w_in_ch;
          end else begin
            r_fmt_err <= 1'b1;
          end
        end
        SEND: begin
          if (dout_ready) begin
            if (w_last) begin
              r_vld        <= '0;
              r_frame_done <= 1'b1;
            end else begin
              r_widx <= w_widx_dec;
              r_dout <= r_words[w_widx_dec];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo_rd_en = (r_state == FETCH);
  assign busy       = (r_state != IDLE);
  assign dout       = r_dout;
  assign dout_vld   = r_vld;
  assign frame_done = r_frame_done;
  assign fmt_err    = r_fmt_err;

endmodule
`default_nettype wire

// File: tb/tb_frame_dispatch.sv
`default_nettype none
// Randomized scoreboard bench for frame_dispatch with a FIFO model and a
// reference model that expands each entry into its expected output events.
module tb_frame_dispatch;

  logic         clk_in = 1'b0;
  logic         rst_n = 1'b0;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [139:0] fifo_rdata = '0;
  logic [15:0]  dout;
  logic [7:0]   dout_vld;
  logic         dout_ready = 1'b0;
  logic         frame_done;
  logic         fmt_err;
  logic         busy;

  frame_dispatch dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .dout_ready (dout_ready),
    .frame_done (frame_done),
    .fmt_err    (fmt_err),
    .busy       (busy)
  );

  always #5 clk_in = ~clk_in;

  // Event kinds: 0 = word accepted, 1 = frame_done, 2 = fmt_err
  typedef struct {
    int         kind;
    logic [7:0] ch;
    logic [15:0] w;
  } exp_t;

  exp_t   exp_q[$];
  logic [139:0] fmem [0:255];
  int     n_push = 0;
  int     n_pop = 0;
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     ready_mode = 0;

  assign fifo_empty = (n_push == n_pop);

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      fifo_rdata <= fmem[n_pop[7:0]];
      n_pop      <= n_pop + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a well-formed entry yields its low cnt words from the
  // highest index down to word 0, then a completion; anything else one fmt_err.
  task automatic push_entry(input logic [127:0] d, input logic [7:0] ch, input logic [3:0] cnt);
    exp_t e;
    fmem[n_push[7:0]] = {d, ch, cnt};
    n_push++;
    if (cnt >= 1 && cnt <= 8 && $countones(ch) == 1) begin
      for (int i = int'(cnt) - 1; i >= 0; i--) begin
        e.kind = 0; e.ch = ch; e.w = d[i*16 +: 16];
        exp_q.push_back(e);
      end
      e.kind = 1; e.ch = '0; e.w = '0;
      exp_q.push_back(e);
    end else begin
      e.kind = 2; e.ch = '0; e.w = '0;
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic drain(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk_in);
      if (exp_q.size() == 0 && n_pop == n_push && !busy) done = 1'b1;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_dout"},       {16'd0, dout}, 32'd0);
    chk({tag, "_dout_vld"},   {24'd0, dout_vld}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_fmt_err"},    {31'd0, fmt_err}, 32'd0);
    chk({tag, "_busy"},       {31'd0, busy}, 32'd0);
    chk({tag, "_fifo_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
  endtask

  // Sink ready pattern: 0 always, 1 = 1,0,0,1 repeating, 2 random, 3 never
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      case (ready_mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       dout_ready = 1'($urandom_range(0, 1));
        default: dout_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every observable event.
  initial begin
    int          vld_chk = -1;
    int          rd_chk = -1;
    logic        prev_hold = 1'b0;
    logic [15:0] prev_dout = '0;
    logic [7:0]  prev_vld = '0;
    exp_t        e;
    forever begin
      @(negedge clk_in);
      if (!rst_n) begin
        prev_hold = 1'b0;
        vld_chk   = -1;
        rd_chk    = -1;
      end else begin
        chk("vld_at_most_one", {31'd0, $countones(dout_vld) <= 1}, 32'd1);
        chk("rd_while_empty", {31'd0, fifo_rd_en && fifo_empty}, 32'd0);
        chk("done_with_err", {31'd0, frame_done && fmt_err}, 32'd0);
        if (prev_hold) begin
          chk("hold_dout", {16'd0, dout}, {16'd0, prev_dout});
          chk("hold_vld", {24'd0, dout_vld}, {24'd0, prev_vld});
        end
        if (rd_chk == cyc) begin
          chk("rd_after_last_accept", {31'd0, fifo_rd_en}, 32'd1);
          rd_chk = -1;
        end
        if (vld_chk == cyc) begin
          chk("first_word_latency", {31'd0, (dout_vld != 0) ^ fmt_err}, 32'd1);
          vld_chk = -1;
        end
        if (fifo_rd_en) vld_chk = cyc + 2;
        if (dout_vld != 0 && dout_ready) begin
          chk("sb_has_word", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("event_is_word", e.kind, 0);
            chk("word_channel", {24'd0, dout_vld}, {24'd0, e.ch});
            chk("word_data", {16'd0, dout}, {16'd0, e.w});
          end
        end
        if (frame_done) begin
          chk("sb_has_done", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("event_is_done", e.kind, 1);
          end
          if (!fifo_empty) rd_chk = cyc + 1;
        end
        if (fmt_err) begin
          chk("sb_has_fmt_err", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("event_is_fmt_err", e.kind, 2);
          end
          if (!fifo_empty) rd_chk = cyc + 1;
        end
        prev_hold = (dout_vld != 0) && !dout_ready;
        prev_dout = dout;
        prev_vld  = dout_vld;
      end
    end
  end

  initial begin
    logic [127:0] d;
    logic [7:0]   ch;
    logic [3:0]   cnt;
    logic         seen;

    // Power-on reset
    repeat (3) @(posedge clk_in);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk_in);
    rst_n = 1'b1;
    ready_mode = 0;

    // Three words on channel 2, sink always ready
    step();
    push_entry({80'd0, 16'hAAAA, 16'hBBBB, 16'hCCCC}, 8'h04, 4'd3);
    drain("drain_three_words");

    // Full entry with a stalling sink
    ready_mode = 1;
    step();
    push_entry({$urandom, $urandom, $urandom, $urandom}, 8'h80, 4'd8);
    drain("drain_stalled_full");

    // Malformed entries followed by a good one
    ready_mode = 0;
    step();
    push_entry({$urandom, $urandom, $urandom, $urandom}, 8'h03, 4'd2);
    push_entry({$urandom, $urandom, $urandom, $urandom}, 8'h01, 4'd0);
    push_entry({$urandom, $urandom, $urandom, $urandom}, 8'h04, 4'd9);
    push_entry({$urandom, $urandom, $urandom, $urandom}, 8'h02, 4'd2);
    drain("drain_malformed");

    // Back-to-back entries on different channels
    step();
    push_entry({$urandom, $urandom, $urandom, $urandom}, 8'h01, 4'd4);
    push_entry({$urandom, $urandom, $urandom, $urandom}, 8'h10, 4'd5);
    drain("drain_back_to_back");

    // Randomized traffic and sink behaviour
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      d   = {$urandom, $urandom, $urandom, $urandom};
      cnt = 4'($urandom_range(0, 10));
      if ($urandom_range(0, 4) == 0) ch = 8'($urandom);
      else                           ch = 8'(1 << $urandom_range(0, 7));
      push_entry(d, ch, cnt);
      repeat ($urandom_range(0, 6)) step();
    end
    drain("drain_random");

    // Empty FIFO for a long stretch
    ready_mode = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_in);
      chk("idle_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    // Reset in the middle of a stalled frame
    ready_mode = 3;
    step();
    push_entry({$urandom, $urandom, $urandom, $urandom}, 8'h20, 4'd8);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk_in);
      if (dout_vld != 0) seen = 1'b1;
    end
    chk("mid_frame_reached", {31'd0, seen}, 32'd1);
    @(posedge clk_in);
    #3;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    exp_q.delete();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    ready_mode = 0;
    repeat (20) @(negedge clk_in);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("post_reset_sb_empty", exp_q.size(), 0);

    // Normal operation resumes after reset
    step();
    push_entry({$urandom, $urandom, $urandom, $urandom}, 8'h08, 4'd6);
    drain("drain_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
